njp_seq_mult: RTL
=================

// Module: njp_seq_mult
// PURPOSE
//  Parametrised sequential shift-add multiplier; successor to the fixed 4x4 micro multiplier.
//  Internal FSM (control) and shift/accumulate datapath; no external control-signal bus.
//  Adds start/busy/done handshake, runtime signed/unsigned mode and a held product register.
//  Sits between the top-level pin mapping and the output pins; one multiply in flight at a time.
// PARAMETERS
//  WIDTH      4   operand width in bits (>=2); product is 2*WIDTH bits
//  SIGNED_EN  1   1: signed_mode port honoured; 0: signed_mode ignored, always unsigned
// PORTS
//  clk          in   1        system clock; all logic on rising edge
//  rst_n        in   1        reset, synchronous, active-low
//  start        in   1        request; sampled only when accept-ready (IDLE or DONE)
//  signed_mode  in   1        1: a,b two's complement; sampled with start
//  a            in   WIDTH    multiplicand; sampled with start
//  b            in   WIDTH    multiplier; sampled with start
//  busy         out  1        high in LOAD/CALC/FIX
//  done         out  1        one-cycle pulse: product valid
//  product      out  2*WIDTH  result; held until next accepted start completes
// BEHAVIOUR
//  Reset (rst_n low at edge): state=IDLE, busy=0, done=0, product=0, internal regs=0.
//  Reset wins over every other event, including mid-CALC; the aborted op gives no done.
//  FSM states and transitions:
//   IDLE : start=1 -> LOAD; otherwise stay.
//   LOAD : register |a|, |b| (two's complement if signed and MSB set), neg=sa^sb;
//          clear acc, cnt=0 -> CALC.
//   CALC : if mplr[0] then acc += mcand (2*WIDTH+1-bit add); mcand<<=1; mplr>>=1; cnt++.
//          Exactly WIDTH CALC cycles, then -> FIX.
//   FIX  : product <= neg ? -acc : acc (2*WIDTH bits, two's complement) -> DONE.
//   DONE : done=1 for this cycle only; start=1 -> LOAD (back-to-back); else -> IDLE.
//  Latency: start sampled at edge N -> done high in the cycle following edge N+WIDTH+2.
//   Fixed latency regardless of operand values (no early exit).
//  Throughput: one result per WIDTH+3 cycles with start held high.
//  Handshake: start while busy=1 is ignored, not queued. a/b/signed_mode are don't-care
//   after the accept edge.
//  Width rules:
//   |a|,|b| held in WIDTH bits unsigned; -2^(WIDTH-1) magnitude fits exactly.
//   Max magnitude (2^WIDTH-1)^2 < 2^(2*WIDTH): no overflow, no saturation.
//   Signed (-2^(W-1))^2 = 2^(2W-2) fits as a positive signed 2W-bit value.
//  Zero operand: normal latency, product=0. Negated zero stays 0 (no -0).
//  product changes only in FIX. It is stable from done until the next FIX.
//  SIGNED_EN=0: sign logic removed, behaviour as signed_mode=0.
// TESTING (WIDTH=4 unless stated)
//  1. unsigned a=15,b=15, start 1 cycle -> busy 1..; done after 6 cycles; product=8'hE1.
//  2. signed a=4'h8(-8),b=4'h8 -> product=8'h40.
//     signed a=4'hD(-3),b=5 -> product=8'hF1.
//  3. same bits a=4'hD,b=5 with signed_mode=0 -> product=8'h41 (65).
//  4. start pulsed again 2 cycles into op with a=1,b=1 -> ignored; first product returned.
//     Exactly one done pulse.
//  5. rst_n low at cycle 3 of CALC -> next edge busy=0, done=0, product=0.
//     A new op afterwards is correct.
//  6. WIDTH=8: start held high, ops 255*255 then 0*77.
//     -> product 16'hFE01, then 16'h0000.
//     Back-to-back with done spacing of 11 cycles.

Source files
------------

// File: rtl/njp_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : njp_seq_mult
//  Purpose  : Parametrised sequential shift-add multiplier with start/busy/
//             done handshake, runtime signed/unsigned mode and held product.
//  Revision : 1.0  initial release
// ============================================================================
module njp_seq_mult #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             accept;
  logic             sign_sel;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplr;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_neg;
  logic [CW-1:0]    cnt;
  logic             neg;

  // Sign handling is compiled out entirely when signed support is disabled.
  generate
    if (SIGNED_EN) begin : g_signed
      assign sign_sel = signed_mode;
    end else begin : g_unsigned
      assign sign_sel = signed_mode & 1'b0;
    end
  endgenerate

  // A request is only taken while the engine is idle or just finished.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Magnitudes fit in WIDTH bits unsigned, including the most negative value.
  assign sa      = sm_q & a_q[WIDTH-1];
  assign sb      = sm_q & b_q[WIDTH-1];
  assign abs_a   = sa ? (~a_q + WIDTH'(1)) : a_q;
  assign abs_b   = sb ? (~b_q + WIDTH'(1)) : b_q;
  assign acc_neg = ~acc + PW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed WIDTH iterations, no early exit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CALC;
      ST_CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == ST_LOAD) || (state == ST_CALC) || (state == ST_FIX);
    done = (state == ST_DONE);
  end

  // Operand capture and shift/accumulate datapath. The accumulator never
  // exceeds (2^WIDTH-1)^2, so 2*WIDTH bits hold every partial sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        sm_q <= sign_sel;
      end
      case (state)
        ST_LOAD: begin
          mcand <= {{(PW - WIDTH){1'b0}}, abs_a};
          mplr  <= abs_b;
          neg   <= sa ^ sb;
          acc   <= '0;
          cnt   <= '0;
        end
        ST_CALC: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
        end
        ST_FIX: begin
          // Negating zero yields zero, so no negative-zero case exists.
          product <= neg ? acc_neg : acc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
